// File: rtl/fetch_unit.sv
// fetch_unit: two-byte instruction fetch sequencer for the 8-bit processor.
// It reads the opcode and then the operand from memory at the program counter.
// Each byte is presented on mdr_o together with a load strobe for the
// instruction register. The PC advances after each byte.
// Optional feature: define FETCH_TIMEOUT_EN to abort a read that goes
// unacknowledged for TIMEOUT cycles.
module fetch_unit #(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter int         TIMEOUT  = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       fetch_start_i,
   input  logic       pc_load_i,
   input  logic [7:0] pc_in_i,
   output logic [7:0] mem_addr_o,
   output logic       mem_rd_o,
   input  logic [7:0] mem_rdata_i,
   input  logic       mem_ack_i,
   output logic [7:0] mdr_o,
   output logic       load_iru_o,
   output logic       load_irl_o,
   output logic [7:0] pc_o,
   output logic       busy_o,
   output logic       fetch_done_o,
   output logic       fetch_err_o
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_U = 3'd1,
      LD_U = 3'd2,
      RD_L = 3'd3,
      LD_L = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] mdr_q, mdr_d;
   logic       memRd;
   logic       loadIru;
   logic       loadIrl;
   logic       fetchDone;
   logic       fetchErr;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
`endif

   // State, PC, data register and wait counter update; reset discards any partial fetch
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         pc_q      <= PC_RESET;
         mdr_q     <= 8'h00;
`ifdef FETCH_TIMEOUT_EN
         waitCnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         mdr_q     <= mdr_d;
`ifdef FETCH_TIMEOUT_EN
         waitCnt_q <= waitCnt_d;
`endif
      end
   end

   // Next-state and output decode; the wait counter falls back to zero outside waiting RD cycles
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      mdr_d     = mdr_q;
      memRd     = 1'b0;
      loadIru   = 1'b0;
      loadIrl   = 1'b0;
      fetchDone = 1'b0;
      fetchErr  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      waitCnt_d = '0;
`endif
      case (state_q)
         IDLE: begin
            if (pc_load_i) begin
               pc_d = pc_in_i;
            end
            if (fetch_start_i) begin
               state_d = RD_U;
            end
         end
         RD_U: begin
            memRd = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            if (waitCnt_q == CNT_W'(TIMEOUT)) begin
               memRd    = 1'b0;
               fetchErr = 1'b1;
               state_d  = IDLE;
            end else
`endif
            if (mem_ack_i) begin
               mdr_d   = mem_rdata_i;
               state_d = LD_U;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
`endif
         end
         LD_U: begin
            loadIru = 1'b1;
            pc_d    = pc_q + 8'd1;
            state_d = RD_L;
         end
         RD_L: begin
            memRd = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            if (waitCnt_q == CNT_W'(TIMEOUT)) begin
               memRd    = 1'b0;
               fetchErr = 1'b1;
               state_d  = IDLE;
            end else
`endif
            if (mem_ack_i) begin
               mdr_d   = mem_rdata_i;
               state_d = LD_L;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
`endif
         end
         LD_L: begin
            loadIrl = 1'b1;
            pc_d    = pc_q + 8'd1;
            state_d = DONE;
         end
         DONE: begin
            fetchDone = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_addr_o   = pc_q;
   assign pc_o         = pc_q;
   assign mdr_o        = mdr_q;
   assign mem_rd_o     = memRd;
   assign load_iru_o   = loadIru;
   assign load_irl_o   = loadIrl;
   assign busy_o       = (state_q != IDLE);
   assign fetch_done_o = fetchDone;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err_o  = fetchErr;
`else
   assign fetch_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The stimulus side builds, for every cycle, the outputs the fetch must show
// (derived from the fetch timeline and a byte-array memory). A compare process
// checks the DUT against that expectation after every rising edge.
module tb_fetch_unit;

   localparam logic [7:0] PC_RST = 8'h00;

   logic       clock = 1'b0;
   logic       reset;
   logic       fetchStart;
   logic       pcLoad;
   logic [7:0] pcIn;
   logic [7:0] memAddr;
   logic       memRd;
   logic [7:0] memRdata;
   logic       memAck;
   logic [7:0] mdr;
   logic       loadIru;
   logic       loadIrl;
   logic [7:0] pc;
   logic       busy;
   logic       fetchDone;
   logic       fetchErr;

   typedef struct {
      logic       busy;
      logic       memRd;
      logic       iru;
      logic       irl;
      logic       done;
      logic       err;
      logic [7:0] addr;
      logic [7:0] pc;
      logic [7:0] mdr;
   } expT;

   expT        expQ[$];
   expT        curExp;
   int         checks = 0;
   int         passes = 0;
   int         cyc = 0;
   int         lastDoneCyc = -1;
   logic [7:0] mem[256];
   logic [7:0] modelPc;
   logic [7:0] modelMdr;

   fetch_unit #(.PC_RESET(PC_RST), .TIMEOUT(16)) dut (
      .clk_i        (clock),
      .reset_i      (reset),
      .fetch_start_i(fetchStart),
      .pc_load_i    (pcLoad),
      .pc_in_i      (pcIn),
      .mem_addr_o   (memAddr),
      .mem_rd_o     (memRd),
      .mem_rdata_i  (memRdata),
      .mem_ack_i    (memAck),
      .mdr_o        (mdr),
      .load_iru_o   (loadIru),
      .load_irl_o   (loadIrl),
      .pc_o         (pc),
      .busy_o       (busy),
      .fetch_done_o (fetchDone),
      .fetch_err_o  (fetchErr)
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Compare one field of the DUT against its expected value
   task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s at cycle %0d: got %02h, expected %02h", name, cyc, act, exp);
   endtask

   // After each rising edge, compare all outputs with the expectation for this cycle
   always @(posedge clock) begin
      cyc++;
      #1;
      if (fetchDone === 1'b1) lastDoneCyc = cyc;
      if (expQ.size() > 0) begin
         curExp = expQ.pop_front();
         checkOutput("busy", {7'd0, busy}, {7'd0, curExp.busy});
         checkOutput("mem_rd", {7'd0, memRd}, {7'd0, curExp.memRd});
         checkOutput("load_iru", {7'd0, loadIru}, {7'd0, curExp.iru});
         checkOutput("load_irl", {7'd0, loadIrl}, {7'd0, curExp.irl});
         checkOutput("fetch_done", {7'd0, fetchDone}, {7'd0, curExp.done});
         checkOutput("fetch_err", {7'd0, fetchErr}, {7'd0, curExp.err});
         checkOutput("mem_addr", memAddr, curExp.addr);
         checkOutput("pc", pc, curExp.pc);
         checkOutput("mdr", mdr, curExp.mdr);
         checkOutput("strobe overlap", {7'd0, loadIru & loadIrl}, 8'h00);
      end
   end

   function automatic expT mk(logic b, logic rd, logic iu, logic il, logic dn, logic er,
                              logic [7:0] p, logic [7:0] m);
      expT e;
      e.busy = b; e.memRd = rd; e.iru = iu; e.irl = il; e.done = dn; e.err = er;
      e.addr = p; e.pc = p; e.mdr = m;
      return e;
   endfunction

   function automatic expT idleRec();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, modelPc, modelMdr);
   endfunction

   // Drive one cycle of inputs and record what the DUT must show in the following cycle
   task automatic applyStimulus(logic r, logic fs, logic pl, logic [7:0] pin,
                                logic ack, logic [7:0] rdata, expT nxt);
      @(negedge clock);
      reset      = r;
      fetchStart = fs;
      pcLoad     = pl;
      pcIn       = pin;
      memAck     = ack;
      memRdata   = rdata;
      expQ.push_back(nxt);
   endtask

   // An idle cycle, optionally loading the PC
   task automatic idleStep(logic pl, logic [7:0] pin);
      if (pl) modelPc = pin;
      applyStimulus(1'b0, 1'b0, pl, pin, 1'b0, 8'h00, idleRec());
   endtask

   // A cycle while busy; mode 1 adds random ignored inputs, mode 2 forces pc_load 8'h40 with fetch_start
   task automatic busyStep(int mode, logic ack, logic [7:0] rdata, expT nxt);
      logic       fs;
      logic       pl;
      logic [7:0] pin;
      fs = 1'b0; pl = 1'b0; pin = 8'h00;
      if (mode == 1) begin
         fs  = 1'($urandom_range(0, 1));
         pl  = 1'($urandom_range(0, 1));
         pin = 8'($urandom);
      end else if (mode == 2) begin
         fs = 1'b1; pl = 1'b1; pin = 8'h40;
      end
      applyStimulus(1'b0, fs, pl, pin, ack, rdata, nxt);
   endtask

   function automatic logic noiseAck(int mode);
      return (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   endfunction

   // One whole fetch; dL < 0 means the operand read is never acknowledged
   task automatic runFetch(logic doLoad, logic [7:0] target, int dU, int dL, int mode,
                           logic rstAtLdU, output int startCyc);
      logic [7:0] p;
      logic [7:0] p1;
      logic [7:0] p2;
      p  = doLoad ? target : modelPc;
      p1 = p + 8'd1;
      p2 = p + 8'd2;
      modelPc = p;
      applyStimulus(1'b0, 1'b1, doLoad, target, noiseAck(mode), 8'($urandom),
                    mk(1, 1, 0, 0, 0, 0, p, modelMdr));
      startCyc = cyc;
      for (int i = 0; i < dU; i++)
         busyStep(mode, 1'b0, 8'($urandom), mk(1, 1, 0, 0, 0, 0, p, modelMdr));
      modelMdr = mem[p];
      busyStep(mode, 1'b1, mem[p], mk(1, 0, 1, 0, 0, 0, p, modelMdr));
      if (rstAtLdU) begin
         modelPc  = PC_RST;
         modelMdr = 8'h00;
         applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, idleRec());
         return;
      end
      busyStep(mode, noiseAck(mode), 8'($urandom), mk(1, 1, 0, 0, 0, 0, p1, modelMdr));
      if (dL < 0) begin
`ifdef FETCH_TIMEOUT_EN
         for (int i = 0; i < 15; i++)
            busyStep(mode, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, p1, modelMdr));
         busyStep(mode, 1'b0, 8'h00, mk(1, 0, 0, 0, 0, 1, p1, modelMdr));
         modelPc = p1;
         busyStep(mode, 1'b0, 8'h00, idleRec());
`else
         for (int i = 0; i < 40; i++)
            busyStep(mode, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, p1, modelMdr));
         modelPc  = PC_RST;
         modelMdr = 8'h00;
         applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, idleRec());
`endif
         return;
      end
      for (int i = 0; i < dL; i++)
         busyStep(mode, 1'b0, 8'($urandom), mk(1, 1, 0, 0, 0, 0, p1, modelMdr));
      modelMdr = mem[p1];
      busyStep(mode, 1'b1, mem[p1], mk(1, 0, 0, 1, 0, 0, p1, modelMdr));
      busyStep(mode, noiseAck(mode), 8'($urandom), mk(1, 0, 0, 0, 1, 0, p2, modelMdr));
      modelPc = p2;
      busyStep(mode, noiseAck(mode), 8'($urandom), idleRec());
   endtask

   // Directed scenarios followed by randomized fetches
   initial begin
      int s;
      int dU;
      int dL;
      reset = 1'b1; fetchStart = 1'b0; pcLoad = 1'b0; pcIn = 8'h00;
      memAck = 1'b0; memRdata = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      modelPc  = PC_RST;
      modelMdr = 8'h00;

      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, idleRec());
      idleStep(1'b0, 8'h00);
      checkOutput("reset pc", pc, 8'h00);
      checkOutput("reset mdr", mdr, 8'h00);
      checkOutput("reset mem_addr", memAddr, 8'h00);

      // Basic fetch with immediate acks
      runFetch(1'b0, 8'h00, 0, 0, 0, 1'b0, s);
      checkOutput("basic done latency", 8'(lastDoneCyc - s), 8'd5);
      idleStep(1'b0, 8'h00);
      checkOutput("basic pc", pc, 8'h02);
      checkOutput("basic mdr operand", mdr, 8'h3C);

      // PC wrap with pc_load and fetch_start together
      runFetch(1'b1, 8'hFF, 0, 0, 0, 1'b0, s);
      idleStep(1'b0, 8'h00);
      checkOutput("wrap pc", pc, 8'h01);

      // Slow memory, three wait cycles per read
      runFetch(1'b0, 8'h00, 3, 3, 0, 1'b0, s);
      checkOutput("slow done latency", 8'(lastDoneCyc - s), 8'd11);
      idleStep(1'b0, 8'h00);

      // Inputs ignored while busy
      runFetch(1'b0, 8'h00, 1, 1, 2, 1'b0, s);
      idleStep(1'b0, 8'h00);
      checkOutput("ignored-input pc", pc, 8'h05);

      // Reset while the opcode strobe is up
      runFetch(1'b0, 8'h00, 0, 0, 0, 1'b1, s);
      idleStep(1'b0, 8'h00);
      checkOutput("mid-reset pc", pc, 8'h00);
      checkOutput("mid-reset mdr", mdr, 8'h00);

      // Randomized fetches with idle gaps and noise
      for (int n = 0; n < 30; n++) begin
         for (int g = 0; g < int'($urandom_range(0, 2)); g++)
            idleStep(1'($urandom_range(0, 1)), 8'($urandom));
         dU = int'($urandom_range(0, 4));
         dL = int'($urandom_range(0, 4));
         runFetch(1'($urandom_range(0, 1)), 8'($urandom), dU, dL, 1, 1'b0, s);
         checkOutput("random done latency", 8'(lastDoneCyc - s), 8'(5 + dU + dL));
      end

      // Operand read never acknowledged
      modelPc  = PC_RST;
      modelMdr = 8'h00;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, idleRec());
      idleStep(1'b0, 8'h00);
      runFetch(1'b0, 8'h00, 0, -1, 0, 1'b0, s);
      idleStep(1'b0, 8'h00);
`ifdef FETCH_TIMEOUT_EN
      checkOutput("timeout pc", pc, 8'h01);
`else
      checkOutput("stuck-then-reset pc", pc, 8'h00);
`endif

      for (int i = 0; i < 3; i++) idleStep(1'b0, 8'h00);
      @(negedge clock);
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
